// File: rtl/csr_pkg.sv
// Shared definitions for the ALU CSR APB slave.
//   state_t    : APB transfer FSM states
//   REG_CTRL   : register index of CTRL
//   reg_res    : register index of RES for n operand registers
//   reg_status : register index of STATUS for n operand registers
package csr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int unsigned REG_CTRL = 0;

    function automatic int unsigned reg_res(input int unsigned n);
        return n + 1;
    endfunction

    function automatic int unsigned reg_status(input int unsigned n);
        return n + 2;
    endfunction

endpackage

// File: rtl/apb_csr_slave_if.sv
// APB bus bundle between a master and the CSR slave.
//   paddr/psel/penable/pwrite/pwdata : master -> slave
//   pready/pslverr/prdata            : slave -> master
interface apb_csr_slave_if #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned APB_BUS_SIZE = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [APB_BUS_SIZE-1:0] pwdata;
    logic                    pready;
    logic                    pslverr;
    logic [APB_BUS_SIZE-1:0] prdata;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/csr_addr_decoder.sv
// Combinational register-map decoder for the CSR slave.
//   addr, write, op      : latched transfer attributes
//   full_in, empty_out   : FIFO flags gating writes / RES reads
//   sel_ctrl, sel_data,
//   sel_res, sel_status  : one-hot register selects
//   err                  : transfer must complete with pslverr
module csr_addr_decoder
    import csr_pkg::*;
#(
    parameter int unsigned NUM_OPERANDS   = 2,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned OPERATION_SIZE = 2,
    parameter logic [(1<<OPERATION_SIZE)-1:0] VALID_OP_MASK = 4'b0110
) (
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      write,
    input  logic [OPERATION_SIZE-1:0] op,
    input  logic                      full_in,
    input  logic                      empty_out,
    output logic                      sel_ctrl,
    output logic [NUM_OPERANDS-1:0]   sel_data,
    output logic                      sel_res,
    output logic                      sel_status,
    output logic                      err
);
    logic [31:0] idx;
    logic        wr_reg;

    always_comb begin
        idx        = 32'(addr);
        sel_ctrl   = (idx == REG_CTRL);
        sel_data   = '0;
        for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
            sel_data[k] = (idx == k + 1);
        end
        sel_res    = (idx == reg_res(NUM_OPERANDS));
        sel_status = (idx == reg_status(NUM_OPERANDS));
        wr_reg     = sel_ctrl | (|sel_data);
        err        = (idx > reg_status(NUM_OPERANDS))
                   | (!write && wr_reg)
                   | (write && (sel_res || sel_status))
                   | (write && wr_reg && full_in)
                   | (!write && sel_res && empty_out)
                   | (write && sel_ctrl && !VALID_OP_MASK[op]);
    end
endmodule

// File: rtl/d_ff_async_en.sv
// Generic register with asynchronous active-high reset to zero and load enable.
//   clk, rst : clock, async reset
//   en       : load enable
//   d, q     : data in / registered data out (WIDTH bits)
module d_ff_async_en #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/apb_csr_slave.sv
// APB slave / control unit for the ALU CSR bank.
//   clk, rst        : clock, async active-high reset
//   apb             : APB slave bundle (pready/pslverr/prdata registered)
//   start_bit       : CTRL start bit from the register bank
//   final_result    : FIFO_OUT head, returned on RES reads
//   fifo_out_status : returned on STATUS reads
//   full_in         : FIFO_IN full, rejects CTRL/operand writes
//   empty_out       : FIFO_OUT empty, rejects RES reads
//   en_ctrl/en_data : register write enable pulses
//   r_en_out        : FIFO_OUT pop pulse
//   w_en_in         : FIFO_IN push pulse
//   proto_err       : one-cycle APB protocol violation flag
module apb_csr_slave
    import csr_pkg::*;
#(
    parameter int unsigned NUM_OPERANDS   = 2,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned APB_BUS_SIZE   = 32,
    parameter int unsigned OPERATION_SIZE = 2,
    parameter int unsigned FIFO_OUT_WIDTH = 25,
    parameter int unsigned RD_WAIT_STATES = 1,
    parameter logic [(1<<OPERATION_SIZE)-1:0] VALID_OP_MASK = 4'b0110
) (
    input  logic                      clk,
    input  logic                      rst,
    apb_csr_slave_if.slave            apb,
    input  logic                      start_bit,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
    input  logic                      full_in,
    input  logic                      empty_out,
    output logic                      en_ctrl,
    output logic [NUM_OPERANDS-1:0]   en_data,
    output logic                      r_en_out,
    output logic                      w_en_in,
    output logic                      proto_err
);
    localparam int unsigned LW = ADDR_WIDTH + 1 + OPERATION_SIZE;

    state_t                    state;
    logic [3:0]                wait_cnt;
    logic                      pready_q, pslverr_q, en_ctrl_q, r_en_q, proto_q;
    logic [APB_BUS_SIZE-1:0]   prdata_q;
    logic [NUM_OPERANDS-1:0]   en_data_q;

    logic                      setup_req, latch_en;
    logic [LW-1:0]             xfer_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      write_q;
    logic [OPERATION_SIZE-1:0] op_q;
    logic                      ctrl_d;

    logic                      sel_ctrl, sel_res, sel_status, dec_err;
    logic [NUM_OPERANDS-1:0]   sel_data;
    logic                      unused_pwdata;

    assign unused_pwdata = ^apb.pwdata[APB_BUS_SIZE-1:OPERATION_SIZE];

    // A new setup phase is accepted from IDLE, or straight after a completed access.
    assign setup_req = apb.psel && !apb.penable;
    assign latch_en  = setup_req && ((state == IDLE) || (state == ACCESS && pready_q));

    d_ff_async_en #(.WIDTH(LW)) u_xfer_ff (
        .clk (clk),
        .rst (rst),
        .en  (latch_en),
        .d   ({apb.paddr, apb.pwrite, apb.pwdata[OPERATION_SIZE-1:0]}),
        .q   (xfer_q)
    );
    assign {addr_q, write_q, op_q} = xfer_q;

    csr_addr_decoder #(
        .NUM_OPERANDS   (NUM_OPERANDS),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .OPERATION_SIZE (OPERATION_SIZE),
        .VALID_OP_MASK  (VALID_OP_MASK)
    ) u_dec (
        .addr       (addr_q),
        .write      (write_q),
        .op         (op_q),
        .full_in    (full_in),
        .empty_out  (empty_out),
        .sel_ctrl   (sel_ctrl),
        .sel_data   (sel_data),
        .sel_res    (sel_res),
        .sel_status (sel_status),
        .err        (dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            en_ctrl_q <= 1'b0;
            en_data_q <= '0;
            r_en_q    <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            en_ctrl_q <= 1'b0;
            en_data_q <= '0;
            r_en_q    <= 1'b0;
            proto_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (apb.penable) begin
                        proto_q <= 1'b1;
                    end else if (apb.psel) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (!apb.psel || !apb.penable) begin
                        proto_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= ACCESS;
                        if (dec_err) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end else if (write_q) begin
                            pready_q  <= 1'b1;
                            en_ctrl_q <= sel_ctrl;
                            en_data_q <= sel_data;
                        end else if (sel_res) begin
                            // Pop now; the data is sampled when pready rises.
                            r_en_q <= 1'b1;
                            if (RD_WAIT_STATES == 0) begin
                                pready_q <= 1'b1;
                                prdata_q <= APB_BUS_SIZE'(final_result);
                            end else begin
                                wait_cnt <= 4'(RD_WAIT_STATES);
                            end
                        end else if (sel_status) begin
                            pready_q <= 1'b1;
                            prdata_q <= APB_BUS_SIZE'(fifo_out_status);
                        end else begin
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (pready_q) begin
                        state <= setup_req ? SETUP : IDLE;
                    end else if (!apb.psel) begin
                        proto_q  <= 1'b1;
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'd1) begin
                        pready_q <= 1'b1;
                        prdata_q <= APB_BUS_SIZE'(final_result);
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push follows the CTRL write by one cycle so the freshly written start bit is seen.
    d_ff_async_en #(.WIDTH(1)) u_ctrl_d (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (en_ctrl_q),
        .q   (ctrl_d)
    );

    assign w_en_in     = ctrl_d & start_bit;
    assign en_ctrl     = en_ctrl_q;
    assign en_data     = en_data_q;
    assign r_en_out    = r_en_q;
    assign proto_err   = proto_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_csr_slave.sv
// Directed self-checking bench for apb_csr_slave (NUM_OPERANDS=2, RD_WAIT_STATES=2).
module tb_apb_csr_slave;

    typedef struct packed {
        int          waits;
        logic        err;
        logic [31:0] rd;
        int          n_ctrl;
        logic        ctrl_rdy;
        int          n_data;
        logic [1:0]  data_rdy;
        int          data_cyc;
        int          n_pop;
        int          n_wen;
        logic        wen_tail;
        logic        done;
    } xr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_bit = 1'b0;
    logic        full_in = 1'b0;
    logic        empty_out = 1'b0;
    logic [24:0] final_result = '0;
    logic [24:0] fifo_out_status = '0;
    logic        en_ctrl, r_en_out, w_en_in, proto_err;
    logic [1:0]  en_data;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    xr_t         r, r2;

    apb_csr_slave_if #(.ADDR_WIDTH(4), .APB_BUS_SIZE(32)) apb ();

    apb_csr_slave #(
        .NUM_OPERANDS   (2),
        .ADDR_WIDTH     (4),
        .APB_BUS_SIZE   (32),
        .OPERATION_SIZE (2),
        .FIFO_OUT_WIDTH (25),
        .RD_WAIT_STATES (2),
        .VALID_OP_MASK  (4'b0110)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .apb             (apb),
        .start_bit       (start_bit),
        .final_result    (final_result),
        .fifo_out_status (fifo_out_status),
        .full_in         (full_in),
        .empty_out       (empty_out),
        .en_ctrl         (en_ctrl),
        .en_data         (en_data),
        .r_en_out        (r_en_out),
        .w_en_in         (w_en_in),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full APB transfer: setup, access until pready (bounded), then one tail cycle.
    task automatic xfer(input logic [3:0] a, input logic w, input logic [31:0] d, output xr_t res);
        int low;
        res = '0;
        res.data_cyc = -1;
        low = 0;
        apb.paddr = a; apb.pwrite = w; apb.pwdata = d;
        apb.psel = 1'b1; apb.penable = 1'b0;
        step();
        apb.penable = 1'b1;
        for (int i = 0; i < 20 && !res.done; i++) begin
            res.n_ctrl += int'(en_ctrl);
            res.n_pop  += int'(r_en_out);
            res.n_wen  += int'(w_en_in);
            res.n_data += int'(en_data != 2'b00);
            if (apb.pready) begin
                res.done     = 1'b1;
                res.err      = apb.pslverr;
                res.rd       = apb.prdata;
                res.ctrl_rdy = en_ctrl;
                res.data_rdy = en_data;
                res.data_cyc = cyc;
            end else begin
                low++;
                step();
            end
        end
        chk("xfer_done", 32'(res.done), 32'(1));
        res.waits = low - 1;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0;
        res.wen_tail = w_en_in;
        res.n_ctrl += int'(en_ctrl);
        res.n_pop  += int'(r_en_out);
        res.n_wen  += int'(w_en_in);
        res.n_data += int'(en_data != 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        apb.paddr = '0; apb.pwrite = 1'b0; apb.pwdata = '0;
        apb.psel = 1'b0; apb.penable = 1'b0;
        start_bit = 1'b1;
        step();
        step();
        chk("rst_bus", {apb.pready, apb.pslverr, en_ctrl, en_data, r_en_out, w_en_in, proto_err}, 32'(0));
        chk("rst_prdata", apb.prdata, 32'h0);
        rst = 1'b0;
        step();

        // CTRL write op=01 with start_bit=1
        xfer(4'd0, 1'b1, 32'h0000_0001, r);
        chk("ctrl_waits", r.waits, 0);
        chk("ctrl_err", 32'(r.err), 32'(0));
        chk("ctrl_en_at_rdy", 32'(r.ctrl_rdy), 32'(1));
        chk("ctrl_en_count", r.n_ctrl, 1);
        chk("ctrl_wen_next", 32'(r.wen_tail), 32'(1));
        chk("ctrl_wen_count", r.n_wen, 1);
        start_bit = 1'b0;

        // RES read with two wait states
        final_result = 25'h1ABCDE;
        xfer(4'd3, 1'b0, 32'h0, r);
        chk("res_waits", r.waits, 2);
        chk("res_err", 32'(r.err), 32'(0));
        chk("res_data", r.rd, 32'h001ABCDE);
        chk("res_pop", r.n_pop, 1);

        // STATUS read: zero wait, no pop
        fifo_out_status = 25'h0123456;
        xfer(4'd4, 1'b0, 32'h0, r);
        chk("stat_waits", r.waits, 0);
        chk("stat_err", 32'(r.err), 32'(0));
        chk("stat_data", r.rd, 32'h00123456);
        chk("stat_pop", r.n_pop, 0);

        // CTRL write with illegal op 11
        xfer(4'd0, 1'b1, 32'h0000_0003, r);
        chk("badop_err", 32'(r.err), 32'(1));
        chk("badop_waits", r.waits, 0);
        chk("badop_en", r.n_ctrl, 0);

        // CTRL write with illegal op 00
        xfer(4'd0, 1'b1, 32'h0000_0000, r);
        chk("op0_err", 32'(r.err), 32'(1));

        // Out-of-range read, first out-of-range address
        xfer(4'd7, 1'b0, 32'h0, r);
        chk("addr7_err", 32'(r.err), 32'(1));
        chk("addr7_data", r.rd, 32'h0);
        xfer(4'd5, 1'b0, 32'h0, r);
        chk("addr5_err", 32'(r.err), 32'(1));

        // RES read while FIFO_OUT empty
        empty_out = 1'b1;
        xfer(4'd3, 1'b0, 32'h0, r);
        chk("empty_err", 32'(r.err), 32'(1));
        chk("empty_waits", r.waits, 0);
        chk("empty_pop", r.n_pop, 0);
        empty_out = 1'b0;

        // Operand write while FIFO_IN full
        full_in = 1'b1;
        xfer(4'd1, 1'b1, 32'h0, r);
        chk("full_err", 32'(r.err), 32'(1));
        chk("full_en", r.n_data, 0);
        full_in = 1'b0;

        // Wrong-direction accesses
        xfer(4'd0, 1'b0, 32'h0, r);
        chk("rd_ctrl_err", 32'(r.err), 32'(1));
        xfer(4'd2, 1'b0, 32'h0, r);
        chk("rd_op_err", 32'(r.err), 32'(1));
        xfer(4'd4, 1'b1, 32'h0, r);
        chk("wr_stat_err", 32'(r.err), 32'(1));

        // Legal op 10 with start_bit=0: enable but no push
        xfer(4'd0, 1'b1, 32'h0000_0002, r);
        chk("op2_err", 32'(r.err), 32'(0));
        chk("op2_en", r.n_ctrl, 1);
        chk("op2_wen", r.n_wen, 0);

        // Back-to-back operand writes
        xfer(4'd1, 1'b1, 32'hFFFF_FFFF, r);
        xfer(4'd2, 1'b1, 32'hFFFF_FFFF, r2);
        chk("b2b_first", 32'(r.data_rdy), 32'(2'b01));
        chk("b2b_second", 32'(r2.data_rdy), 32'(2'b10));
        chk("b2b_spacing", r2.data_cyc - r.data_cyc, 3);
        chk("b2b_count", r.n_data + r2.n_data, 2);

        // penable without psel in IDLE
        apb.penable = 1'b1;
        step();
        apb.penable = 1'b0;
        chk("proto_idle", 32'(proto_err), 32'(1));
        step();
        chk("proto_idle_clr", 32'(proto_err), 32'(0));

        // psel dropped in SETUP
        apb.paddr = 4'd4; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        step();
        apb.psel = 1'b0;
        step();
        chk("proto_setup", {apb.pready, proto_err}, 32'(2'b01));

        // psel dropped during RES wait
        step();
        apb.paddr = 4'd3; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        step();
        apb.penable = 1'b1;
        step();
        chk("drop_pop", {apb.pready, r_en_out}, 32'(2'b01));
        apb.psel = 1'b0; apb.penable = 1'b0;
        step();
        chk("drop_proto", {apb.pready, r_en_out, proto_err}, 32'(3'b001));
        step();
        chk("drop_proto_clr", 32'(proto_err), 32'(0));
        xfer(4'd4, 1'b0, 32'h0, r);
        chk("after_drop_data", r.rd, 32'h00123456);
        chk("after_drop_waits", r.waits, 0);

        // Reset in the middle of a RES access
        start_bit = 1'b1;
        apb.paddr = 4'd3; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        step();
        apb.penable = 1'b1;
        step();
        chk("rst_pre_pop", 32'(r_en_out), 32'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_out", {apb.pready, apb.pslverr, en_ctrl, en_data, r_en_out, w_en_in, proto_err}, 32'(0));
        chk("rst_mid_prdata", apb.prdata, 32'h0);
        apb.psel = 1'b0; apb.penable = 1'b0;
        step();
        rst = 1'b0;
        step();
        start_bit = 1'b0;
        xfer(4'd3, 1'b0, 32'h0, r);
        chk("after_rst_data", r.rd, 32'h001ABCDE);
        chk("after_rst_waits", r.waits, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
